data_buffer: RTL and testbench

- Capture buffer that records CYCLES consecutive SIZE-bit samples of `data` once `data_start` is asserted.
- Holds the captured block for random-access readback and flags completion.
- Sits between a streaming sample source and a slower consumer that reads the block at leisure.

---
 rtl/data_buffer.sv | 117 +++++++++++
 tb/tb_data_buffer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_buffer.sv
// Capture buffer: records CYCLES consecutive samples after data_start and holds them for random-access readback.
// Latency: first word is stored on the start edge, and done pulses CYCLES-1 edges later. rd_data is combinational.
// Backpressure: none. A burst always completes. DATA_BUFFER_CHECKSUM_EN adds a running XOR checksum output.
module data_buffer #(
  parameter int CYCLES = 8,
  parameter int SIZE   = 16
) (
  input  logic                         data_start,
  input  logic [SIZE-1:0]              data,
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [$clog2(CYCLES)-1:0]    rd_addr,
  output logic [SIZE-1:0]              rd_data,
  output logic [SIZE-1:0]              buffer,
  output logic [$clog2(CYCLES+1)-1:0]  count,
  output logic                         busy,
  output logic                         done,
  output logic                         full
`ifdef DATA_BUFFER_CHECKSUM_EN
  ,
  output logic [SIZE-1:0]              checksum
`endif
);

  localparam int AW = $clog2(CYCLES);
  localparam int CW = $clog2(CYCLES+1);

  typedef enum logic [1:0] {IDLE, CAPTURE, FULL} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SIZE-1:0] buffer_q, buffer_d;
  logic            done_q, done_d;
  logic [SIZE-1:0] csum_q, csum_d;
  logic            we;
  logic [AW-1:0]   wr_addr;
  logic [SIZE-1:0] mem_q [CYCLES];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      buffer_q <= '0;
      done_q   <= 1'b0;
      csum_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      buffer_q <= buffer_d;
      done_q   <= done_d;
      csum_q   <= csum_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    buffer_d = buffer_q;
    done_d   = 1'b0;
    csum_d   = csum_q;
    we       = 1'b0;
    wr_addr  = '0;
    case (state_q)
      IDLE: begin
        if (data_start) begin
          we       = 1'b1;
          buffer_d = data;
          count_d  = CW'(1);
          csum_d   = data;
          state_d  = CAPTURE;
        end
      end
      CAPTURE: begin
        // count_q is the index being written; it is always below CYCLES here.
        we       = 1'b1;
        wr_addr  = AW'(count_q);
        buffer_d = data;
        count_d  = count_q + CW'(1);
        csum_d   = csum_q ^ data;
        if (count_q == CW'(CYCLES-1)) begin
          done_d  = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (!data_start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CYCLES; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[wr_addr] <= data;
    end
  end

  generate
    if ((1 << AW) == CYCLES) begin : g_rd_pow2
      assign rd_data = mem_q[rd_addr];
    end else begin : g_rd_guard
      assign rd_data = (32'(rd_addr) < CYCLES) ? mem_q[rd_addr] : '0;
    end
  endgenerate

  assign buffer = buffer_q;
  assign count  = count_q;
  assign busy   = (state_q == CAPTURE);
  assign done   = done_q;
  assign full   = (state_q == FULL);
`ifdef DATA_BUFFER_CHECKSUM_EN
  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_data_buffer.sv
// Randomized scoreboard bench for data_buffer: stimulus queues expected bursts/snapshots, a negedge monitor checks them.
`timescale 1ns/100ps
module tb_data_buffer;
  localparam int CYCLES = 8;
  localparam int SIZE   = 16;
  localparam int AW     = $clog2(CYCLES);
  localparam int CW     = $clog2(CYCLES+1);

  typedef logic [SIZE-1:0] word_t;
  typedef struct {
    word_t w [CYCLES];
    int    cnt;
    word_t bufw;
    logic  full;
    logic  busy;
    word_t cs;
    int    due;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          data_start = 1'b0;
  word_t         data = '0;
  logic [AW-1:0] rd_addr = '0;
  word_t         rd_data, buffer;
  logic [CW-1:0] count;
  logic          busy, done, full;
`ifdef DATA_BUFFER_CHECKSUM_EN
  word_t         checksum;
`endif

  exp_t  exp_q[$];
  exp_t  snap_q[$];
  word_t model_mem [CYCLES];
  int    model_cnt;
  word_t model_buf, model_cs;
  logic  model_full;
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;

  data_buffer #(.CYCLES(CYCLES), .SIZE(SIZE)) dut (
    .data_start(data_start),
    .data      (data),
    .clock     (clock),
    .reset_n   (reset_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .buffer    (buffer),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .full      (full)
`ifdef DATA_BUFFER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #10 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic compare(input exp_t e, input bit at_done);
    chk("count", 32'(count), e.cnt);
    chk("full", 32'(full), 32'(e.full));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("buffer", 32'(buffer), 32'(e.bufw));
    if (at_done) chk("done_latency", cyc, e.due);
`ifdef DATA_BUFFER_CHECKSUM_EN
    chk("checksum", 32'(checksum), 32'(e.cs));
`endif
    for (int a = 0; a < CYCLES; a++) begin
      rd_addr = AW'(a);
      #1;
      chk($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'(e.w[a]));
    end
  endtask

  // Monitor: a done pulse consumes one expected burst; otherwise a pending snapshot is checked.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        compare(exp_q.pop_front(), 1'b1);
      end
    end else if (snap_q.size() != 0) begin
      compare(snap_q.pop_front(), 1'b0);
    end
  end

  function automatic exp_t model_snap();
    exp_t e;
    for (int i = 0; i < CYCLES; i++) e.w[i] = model_mem[i];
    e.cnt  = model_cnt;
    e.bufw = model_buf;
    e.full = model_full;
    e.busy = 1'b0;
    e.cs   = model_cs;
    e.due  = 0;
    return e;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < CYCLES; i++) model_mem[i] = '0;
    model_cnt  = 0;
    model_buf  = '0;
    model_cs   = '0;
    model_full = 1'b0;
  endtask

  task automatic wait_snap();
    for (int i = 0; i < 5 && snap_q.size() != 0; i++) step();
    chk("snapshot_served", snap_q.size(), 0);
    snap_q.delete();
  endtask

  task automatic do_reset(input int n);
    reset_n    = 1'b0;
    data_start = 1'b0;
    clear_model();
    repeat (n) step();
    snap_q.push_back(model_snap());
    wait_snap();
    reset_n = 1'b1;
    step();
  endtask

  // kind: 0 random words, 1 words 1..CYCLES, 2 A5A5 first then random
  task automatic run_burst(input int kind, input int hold, input bit quick);
    exp_t e;
    for (int i = 0; i < CYCLES; i++) begin
      case (kind)
        1:       e.w[i] = word_t'(i + 1);
        2:       e.w[i] = (i == 0) ? word_t'(16'hA5A5) : word_t'($urandom);
        default: e.w[i] = word_t'($urandom);
      endcase
    end
    e.cs = '0;
    for (int i = 0; i < CYCLES; i++) e.cs = e.cs ^ e.w[i];
    e.cnt  = CYCLES;
    e.bufw = e.w[CYCLES-1];
    e.full = 1'b1;
    e.busy = 1'b0;
    data_start = 1'b1;
    data = e.w[0];
    step();
    e.due = cyc + CYCLES - 1;
    exp_q.push_back(e);
    for (int i = 1; i < CYCLES; i++) begin
      data = e.w[i];
      data_start = 1'($urandom);
      step();
    end
    data_start = 1'b1;
    for (int i = 0; i < hold; i++) begin
      data = word_t'($urandom);
      step();
    end
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) step();
    chk("done_seen", exp_q.size(), 0);
    exp_q.delete();
    for (int i = 0; i < CYCLES; i++) model_mem[i] = e.w[i];
    model_cnt  = CYCLES;
    model_buf  = e.bufw;
    model_cs   = e.cs;
    model_full = 1'b1;
    snap_q.push_back(model_snap());
    wait_snap();
    data_start = 1'b0;
    data = word_t'($urandom);
    step();
    model_full = 1'b0;
    if (!quick) begin
      snap_q.push_back(model_snap());
      wait_snap();
    end
  endtask

  task automatic abort_burst(input int k);
    data_start = 1'b1;
    for (int i = 0; i < k; i++) begin
      data = word_t'($urandom);
      step();
    end
    reset_n = 1'b0;
    data_start = 1'b0;
    #1;
    clear_model();
    snap_q.push_back(model_snap());
    wait_snap();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    do_reset(2);
    run_burst(1, 20, 1'b1);
    run_burst(2, 0, 1'b0);
    abort_burst(3);
    run_burst(1, 2, 1'b0);
    for (int n = 0; n < 6; n++) begin
      run_burst(0, $urandom_range(0, 5), 1'($urandom));
      if (n == 3) abort_burst($urandom_range(1, CYCLES - 1));
    end
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
